laser_cover: RTL and testbench

Parametrised two-circle coverage solver, successor of the fixed 16×16 / 40-object engine.
- Loads NUM_OBJ points over a valid-qualified input and places two radius-RADIUS circles on a 2^COORD_W square grid by alternating exhaustive sweeps, maximising the union of covered points.
- Reports both centres, the union count and a one-cycle DONE.
- Sits between the point-stream source and the result collector in the ICDC laser-placement flow.

---
 rtl/laser_pkg.sv | 34 +++
 rtl/laser_inside.sv | 37 +++
 rtl/laser_cover.sv | 243 ++++++++++++++++++++++++
 tb/tb_laser_cover.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// laser_pkg: shared state encoding and width helpers for the laser_cover solver.
package laser_pkg;

    typedef enum logic [2:0] {
        StLoad,
        StSweepC1,
        StUpdC1,
        StSweepC2,
        StUpdC2,
        StTally,
        StFinish
    } state_t;

    // Side length of the square grid.
    function automatic int unsigned grid_size(input int unsigned coord_w);
        return 32'd1 << coord_w;
    endfunction

    // Width of a raster index {cy,cx}.
    function automatic int unsigned idx_w(input int unsigned coord_w);
        return 2 * coord_w;
    endfunction

    // Number of candidate centres on the grid.
    function automatic int unsigned grid_cells(input int unsigned coord_w);
        return grid_size(coord_w) * grid_size(coord_w);
    endfunction

    // Squared radius used as the coverage threshold.
    function automatic int unsigned radius_sq(input int unsigned radius);
        return radius * radius;
    endfunction

endpackage

// File: rtl/laser_inside.sv
// laser_inside: combinational test of whether a point lies inside a circle.
// An inactive circle never covers anything. No wrap-around across grid edges.
module laser_inside
    import laser_pkg::*;
#(
    parameter int unsigned COORD_W = 4,
    parameter int unsigned RADIUS  = 4
) (
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    input  logic               active_i,
    output logic               inside_o
);

    localparam int unsigned SqW   = 2 * COORD_W;
    localparam int unsigned DistW = 2 * COORD_W + 1;
    localparam logic [DistW-1:0] RadSq = DistW'(radius_sq(RADIUS));

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [SqW-1:0]     dx_sq;
    logic [SqW-1:0]     dy_sq;
    logic [DistW-1:0]   dist_sq;

    // Absolute deltas, squared and summed, compared against RADIUS^2.
    always_comb begin
        dx       = (cx_i >= px_i) ? (cx_i - px_i) : (px_i - cx_i);
        dy       = (cy_i >= py_i) ? (cy_i - py_i) : (py_i - cy_i);
        dx_sq    = SqW'(dx) * SqW'(dx);
        dy_sq    = SqW'(dy) * SqW'(dy);
        dist_sq  = DistW'(dx_sq) + DistW'(dy_sq);
        inside_o = active_i && (dist_sq <= RadSq);
    end

endmodule

// File: rtl/laser_cover.sv
// laser_cover: loads NUM_OBJ points, then places two circles by alternating exhaustive
// sweeps over the grid to maximise the union of covered points.
// Build option LASER_TIE_LAST_EN: sweep ties pick the last raster candidate instead of
// the first.
module laser_cover
    import laser_pkg::*;
#(
    parameter int unsigned COORD_W  = 4,
    parameter int unsigned NUM_OBJ  = 40,
    parameter int unsigned RADIUS   = 4,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         IN_VALID,
    input  logic [COORD_W-1:0]           X,
    input  logic [COORD_W-1:0]           Y,
    output logic                         BUSY,
    output logic [COORD_W-1:0]           C1X,
    output logic [COORD_W-1:0]           C1Y,
    output logic [COORD_W-1:0]           C2X,
    output logic [COORD_W-1:0]           C2Y,
    output logic [$clog2(NUM_OBJ+1)-1:0] COUNT,
    output logic                         DONE
);

    localparam int unsigned IdxW  = idx_w(COORD_W);
    localparam int unsigned CntW  = $clog2(NUM_OBJ + 1);
    localparam int unsigned PtrW  = $clog2(NUM_OBJ);
    localparam int unsigned IterW = $clog2(MAX_ITER + 1);

    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NUM_OBJ - 1);
    localparam logic [IdxW-1:0]  CandLast = IdxW'(grid_cells(COORD_W) - 1);
    localparam logic [IterW-1:0] IterOne  = IterW'(1);
    localparam logic [IterW-1:0] IterMax  = IterW'(MAX_ITER);

    state_t             state_q;
    logic [COORD_W-1:0] obj_x_q [NUM_OBJ];
    logic [COORD_W-1:0] obj_y_q [NUM_OBJ];
    logic [PtrW-1:0]    ptr_q;
    logic [IdxW-1:0]    cand_q;
    logic [IdxW-1:0]    best_idx_q;
    logic [CntW-1:0]    acc_q;
    logic [CntW-1:0]    best_cnt_q;
    logic [CntW-1:0]    count_q;
    logic [IterW-1:0]   iter_q;
    logic [COORD_W-1:0] c1x_q;
    logic [COORD_W-1:0] c1y_q;
    logic [COORD_W-1:0] c2x_q;
    logic [COORD_W-1:0] c2y_q;
    logic               c2_act_q;
    logic               c1_chg_q;
    logic               done_q;
    logic               busy_q;

    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic [COORD_W-1:0] ca_x;
    logic [COORD_W-1:0] ca_y;
    logic [COORD_W-1:0] cb_x;
    logic [COORD_W-1:0] cb_y;
    logic               cb_act;
    logic               in_a;
    logic               in_b;
    logic               hit;
    logic               better;
    logic               last_obj;
    logic [CntW-1:0]    acc_sum;
    logic [IdxW-1:0]    c1_idx;
    logic [IdxW-1:0]    c2_idx;

    // Route circle A (candidate, or C1 in TALLY) and circle B (the other circle).
    always_comb begin
        pt_x   = obj_x_q[ptr_q];
        pt_y   = obj_y_q[ptr_q];
        ca_x   = cand_q[COORD_W-1:0];
        ca_y   = cand_q[IdxW-1:COORD_W];
        cb_x   = c2x_q;
        cb_y   = c2y_q;
        cb_act = c2_act_q;
        if (state_q == StSweepC2) begin
            cb_x   = c1x_q;
            cb_y   = c1y_q;
            cb_act = 1'b1;
        end else if (state_q == StTally) begin
            ca_x   = c1x_q;
            ca_y   = c1y_q;
            cb_act = 1'b1;
        end
    end

    laser_inside #(
        .COORD_W (COORD_W),
        .RADIUS  (RADIUS)
    ) u_inside_a (
        .cx_i     (ca_x),
        .cy_i     (ca_y),
        .px_i     (pt_x),
        .py_i     (pt_y),
        .active_i (1'b1),
        .inside_o (in_a)
    );

    laser_inside #(
        .COORD_W (COORD_W),
        .RADIUS  (RADIUS)
    ) u_inside_b (
        .cx_i     (cb_x),
        .cy_i     (cb_y),
        .px_i     (pt_x),
        .py_i     (pt_y),
        .active_i (cb_act),
        .inside_o (in_b)
    );

    // Sweeps count new coverage only; TALLY counts the union.
    always_comb begin
        hit      = (state_q == StTally) ? (in_a | in_b) : (in_a & ~in_b);
        acc_sum  = acc_q + CntW'(hit);
        last_obj = (ptr_q == PtrLast);
        c1_idx   = {c1y_q, c1x_q};
        c2_idx   = {c2y_q, c2x_q};
`ifdef LASER_TIE_LAST_EN
        better   = (acc_sum >= best_cnt_q);
`else
        better   = (acc_sum > best_cnt_q);
`endif
    end

    // Control FSM with point storage and registered results.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= StLoad;
            for (int i = 0; i < NUM_OBJ; i++) begin
                obj_x_q[i] <= '0;
                obj_y_q[i] <= '0;
            end
            ptr_q      <= '0;
            cand_q     <= '0;
            best_idx_q <= '0;
            acc_q      <= '0;
            best_cnt_q <= '0;
            count_q    <= '0;
            iter_q     <= '0;
            c1x_q      <= '0;
            c1y_q      <= '0;
            c2x_q      <= '0;
            c2y_q      <= '0;
            c2_act_q   <= 1'b0;
            c1_chg_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    if (IN_VALID) begin
                        obj_x_q[ptr_q] <= X;
                        obj_y_q[ptr_q] <= Y;
                        if (last_obj) begin
                            // New problem: previous results are dropped here.
                            ptr_q    <= '0;
                            cand_q   <= '0;
                            acc_q    <= '0;
                            iter_q   <= IterOne;
                            c2_act_q <= 1'b0;
                            busy_q   <= 1'b1;
                            c1x_q    <= '0;
                            c1y_q    <= '0;
                            c2x_q    <= '0;
                            c2y_q    <= '0;
                            count_q  <= '0;
                            state_q  <= StSweepC1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                StSweepC1, StSweepC2: begin
                    if (last_obj) begin
                        if ((cand_q == '0) || better) begin
                            best_cnt_q <= acc_sum;
                            best_idx_q <= cand_q;
                        end
                        acc_q  <= '0;
                        ptr_q  <= '0;
                        cand_q <= cand_q + 1'b1;
                        if (cand_q == CandLast) begin
                            state_q <= (state_q == StSweepC1) ? StUpdC1 : StUpdC2;
                        end
                    end else begin
                        acc_q <= acc_sum;
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                StUpdC1: begin
                    c1x_q    <= best_idx_q[COORD_W-1:0];
                    c1y_q    <= best_idx_q[IdxW-1:COORD_W];
                    c1_chg_q <= (best_idx_q != c1_idx);
                    c2_act_q <= 1'b1;
                    state_q  <= StSweepC2;
                end
                StUpdC2: begin
                    c2x_q <= best_idx_q[COORD_W-1:0];
                    c2y_q <= best_idx_q[IdxW-1:COORD_W];
                    if (((iter_q != IterOne) && !c1_chg_q && (best_idx_q == c2_idx)) ||
                        (iter_q == IterMax)) begin
                        state_q <= StTally;
                    end else begin
                        iter_q  <= iter_q + 1'b1;
                        state_q <= StSweepC1;
                    end
                end
                StTally: begin
                    if (last_obj) begin
                        count_q <= acc_sum;
                        acc_q   <= '0;
                        ptr_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        acc_q <= acc_sum;
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign BUSY  = busy_q;
    assign C1X   = c1x_q;
    assign C1Y   = c1y_q;
    assign C2X   = c2x_q;
    assign C2Y   = c2y_q;
    assign COUNT = count_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_laser_cover.sv
// tb_laser_cover: directed scenarios with hand-computed centres, counts and timing.
`timescale 1ns/1ps
module tb_laser_cover;

    localparam int unsigned COORD_W = 4;
    localparam int unsigned NUM_OBJ = 8;
    localparam int unsigned SWEEP   = (1 << (2 * COORD_W)) * NUM_OBJ;
    localparam int unsigned BUDGET  = 12000;

`ifdef LASER_TIE_LAST_EN
    localparam int unsigned S1_C1X = 5,  S1_C1Y = 9,  S1_C2X = 15, S1_C2Y = 15;
    localparam int unsigned S2_C1X = 14, S2_C1Y = 15, S2_C2X = 2,  S2_C2Y = 6;
    localparam int unsigned S4_C1X = 0,  S4_C1Y = 4,  S4_C2X = 15, S4_C2Y = 15;
`else
    localparam int unsigned S1_C1X = 5,  S1_C1Y = 1,  S1_C2X = 0,  S1_C2Y = 0;
    localparam int unsigned S2_C1X = 0,  S2_C1Y = 0,  S2_C2X = 12, S2_C2Y = 8;
    localparam int unsigned S4_C1X = 0,  S4_C1Y = 0,  S4_C2X = 15, S4_C2Y = 11;
`endif

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         IN_VALID;
    logic         IN_VALID1;
    logic [3:0]   X;
    logic [3:0]   Y;
    logic         BUSY, DONE, BUSY1, DONE1;
    logic [3:0]   C1X, C1Y, C2X, C2Y, COUNT;
    logic [3:0]   C1X_1, C1Y_1, C2X_1, C2Y_1, COUNT_1;

    int n_cmp = 0;
    int n_err = 0;
    int edges;
    bit seen;

    always #5 CLK = ~CLK;

    laser_cover #(
        .COORD_W  (COORD_W),
        .NUM_OBJ  (NUM_OBJ),
        .RADIUS   (4),
        .MAX_ITER (8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_VALID (IN_VALID),
        .X        (X),
        .Y        (Y),
        .BUSY     (BUSY),
        .C1X      (C1X),
        .C1Y      (C1Y),
        .C2X      (C2X),
        .C2Y      (C2Y),
        .COUNT    (COUNT),
        .DONE     (DONE)
    );

    laser_cover #(
        .COORD_W  (COORD_W),
        .NUM_OBJ  (NUM_OBJ),
        .RADIUS   (4),
        .MAX_ITER (1)
    ) dut_one (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_VALID (IN_VALID1),
        .X        (X),
        .Y        (Y),
        .BUSY     (BUSY1),
        .C1X      (C1X_1),
        .C1Y      (C1Y_1),
        .C2X      (C2X_1),
        .C2Y      (C2Y_1),
        .COUNT    (COUNT_1),
        .DONE     (DONE1)
    );

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Load na points at (ax,ay) then nb at (bx,by); optional idle cycle after each point.
    task automatic load_pts(input bit to1, input logic [3:0] ax, input logic [3:0] ay,
                            input int na, input logic [3:0] bx, input logic [3:0] by,
                            input int nb, input bit gaps);
        for (int i = 0; i < na + nb; i++) begin
            X = (i < na) ? ax : bx;
            Y = (i < na) ? ay : by;
            if (to1) IN_VALID1 = 1'b1;
            else     IN_VALID  = 1'b1;
            if (i == na + nb - 1) check_eq("busy_before_last", to1 ? BUSY1 : BUSY, 0);
            step();
            if (gaps || (i == na + nb - 1)) begin
                IN_VALID  = 1'b0;
                IN_VALID1 = 1'b0;
            end
            if (gaps && (i != na + nb - 1)) step();
        end
    endtask

    task automatic wait_done(input bit on1, input int budget, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && (n < budget)) begin
            step();
            n++;
            if ((on1 ? DONE1 : DONE) === 1'b1) got = 1'b1;
        end
        check_eq("done_within_budget", got, 1);
    endtask

    task automatic check_result(input string pfx, input bit on1,
                                input int unsigned e1x, input int unsigned e1y,
                                input int unsigned e2x, input int unsigned e2y,
                                input int unsigned ecnt);
        check_eq({pfx, "_c1x"},   on1 ? C1X_1   : C1X,   e1x);
        check_eq({pfx, "_c1y"},   on1 ? C1Y_1   : C1Y,   e1y);
        check_eq({pfx, "_c2x"},   on1 ? C2X_1   : C2X,   e2x);
        check_eq({pfx, "_c2y"},   on1 ? C2Y_1   : C2Y,   e2y);
        check_eq({pfx, "_count"}, on1 ? COUNT_1 : COUNT, ecnt);
    endtask

    task automatic check_after_done(input string pfx, input bit on1);
        step();
        check_eq({pfx, "_done_one_cycle"}, on1 ? DONE1 : DONE, 0);
        check_eq({pfx, "_busy_low_after"}, on1 ? BUSY1 : BUSY, 0);
    endtask

    initial begin
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_VALID1 = 1'b0;
        X         = '0;
        Y         = '0;
        step();
        step();
        RST_N = 1'b1;

        check_result("reset", 1'b0, 0, 0, 0, 0, 0);
        check_eq("reset_busy", BUSY, 0);
        check_eq("reset_done", DONE, 0);

        // All points stacked at (5,5); converges after iteration 2.
        load_pts(1'b0, 4'd5, 4'd5, NUM_OBJ, 4'd0, 4'd0, 0, 1'b0);
        check_eq("s1_busy_rise", BUSY, 1);
        wait_done(1'b0, BUDGET, edges, seen);
        check_eq("s1_done_latency", edges + 1, 4 * (SWEEP + 1) + NUM_OBJ + 1);
        check_result("s1", 1'b0, S1_C1X, S1_C1Y, S1_C2X, S1_C2Y, NUM_OBJ);
        check_after_done("s1", 1'b0);

        // Two clusters at (2,2) and (12,12).
        load_pts(1'b0, 4'd2, 4'd2, NUM_OBJ / 2, 4'd12, 4'd12, NUM_OBJ / 2, 1'b0);
        check_eq("s2_busy_rise", BUSY, 1);
        wait_done(1'b0, BUDGET, edges, seen);
        check_result("s2", 1'b0, S2_C1X, S2_C1Y, S2_C2X, S2_C2Y, NUM_OBJ);
        check_after_done("s2", 1'b0);

        // Same points with gapped IN_VALID, then IN_VALID held with junk while busy.
        load_pts(1'b0, 4'd2, 4'd2, NUM_OBJ / 2, 4'd12, 4'd12, NUM_OBJ / 2, 1'b1);
        check_eq("s3_busy_rise", BUSY, 1);
        X        = 4'd7;
        Y        = 4'd7;
        IN_VALID = 1'b1;
        wait_done(1'b0, BUDGET, edges, seen);
        IN_VALID = 1'b0;
        check_result("s3", 1'b0, S2_C1X, S2_C1Y, S2_C2X, S2_C2Y, NUM_OBJ);
        check_after_done("s3", 1'b0);

        // Reset in the middle of the C2 sweep.
        load_pts(1'b0, 4'd5, 4'd5, NUM_OBJ, 4'd0, 4'd0, 0, 1'b0);
        repeat (SWEEP + 300) step();
        check_eq("rst_pre_c1y", C1Y, S1_C1Y);
        check_eq("rst_pre_busy", BUSY, 1);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check_result("rst_mid", 1'b0, 0, 0, 0, 0, 0);
        check_eq("rst_mid_busy", BUSY, 0);
        check_eq("rst_mid_done", DONE, 0);

        // Fresh load after reset: cluster at (0,0) plus a lone corner point.
        load_pts(1'b0, 4'd0, 4'd0, NUM_OBJ - 1, 4'd15, 4'd15, 1, 1'b0);
        check_eq("s4_busy_rise", BUSY, 1);
        wait_done(1'b0, BUDGET, edges, seen);
        check_result("s4", 1'b0, S4_C1X, S4_C1Y, S4_C2X, S4_C2Y, NUM_OBJ);
        check_after_done("s4", 1'b0);

        // Iteration cap of 1: TALLY right after the first UPD_C2.
        load_pts(1'b1, 4'd2, 4'd2, NUM_OBJ / 2, 4'd12, 4'd12, NUM_OBJ / 2, 1'b0);
        check_eq("s5_busy_rise", BUSY1, 1);
        wait_done(1'b1, BUDGET, edges, seen);
        check_eq("s5_done_latency", edges + 1, 2 * (SWEEP + 1) + NUM_OBJ + 1);
        check_result("s5", 1'b1, S2_C1X, S2_C1Y, S2_C2X, S2_C2Y, NUM_OBJ);
        check_after_done("s5", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
